// File: rtl/bit_serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding and width limit.
package bsa_pkg;

    localparam int BSA_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bsa_state_e;

endpackage

// File: rtl/bit_serial_add_ctrl_if.sv
// Operand/result bundle between the operand source (master) and the serial adder (slave).
interface bit_serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic [WIDTH-1:0] op_a_i;
    logic [WIDTH-1:0] op_b_i;
    logic             cin_i;
    logic             sub_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;

    modport master (
        output start_i, op_a_i, op_b_i, cin_i, sub_i,
        input  busy_o, done_o, sum_o, cout_o
    );

    modport slave (
        input  start_i, op_a_i, op_b_i, cin_i, sub_i,
        output busy_o, done_o, sum_o, cout_o
    );
endinterface

// File: rtl/bit_serial_add_ctrl_fa_cell.sv
// Single combinational full-adder cell, time-shared across all bit positions.
module serial_fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);
    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer, LSB first through one shared full-adder cell.
// Optional subtract mode enabled by defining BSA_SUB_EN.
module bit_serial_add_ctrl
    import bsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    bit_serial_add_ctrl_if.slave        bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    if (WIDTH < 1 || WIDTH > BSA_MAX_WIDTH) begin : g_width_chk
        $error("bit_serial_add_ctrl: WIDTH out of range");
    end

    bsa_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_sum, fa_cout;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    serial_fa_cell u_cell (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    // Sum bits enter at the MSB so after WIDTH shifts the result is aligned.
    if (WIDTH == 1) begin : g_res_w1
        assign res_shift = fa_sum;
    end else begin : g_res_wn
        assign res_shift = {fa_sum, res_q[WIDTH-1:1]};
    end

`ifdef BSA_SUB_EN
    assign b_load = bus.sub_i ? ~bus.op_b_i : bus.op_b_i;
    assign c_load = bus.sub_i ? 1'b1 : bus.cin_i;
`else
    logic unused_sub;
    assign unused_sub = bus.sub_i;
    assign b_load     = bus.op_b_i;
    assign c_load     = bus.cin_i;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    a_d     = bus.op_a_i;
                    b_d     = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                carry_d = fa_cout;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_shift;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    sum_d   = res_shift;
                    cout_d  = fa_cout;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy_o = (state_q == RUN);
    assign bus.done_o = (state_q == DONE);
    assign bus.sum_o  = sum_q;
    assign bus.cout_o = cout_q;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Directed and randomized checks of bit_serial_add_ctrl at WIDTH = 1, 8 and 32.
module tb_bit_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_v = 1'b0;
    logic        cin_v = 1'b0;
    logic        sub_v = 1'b0;
    logic [31:0] a_v = '0;
    logic [31:0] b_v = '0;
    int          sel = 8;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    bit_serial_add_ctrl_if #(.WIDTH(1))  b1 ();
    bit_serial_add_ctrl_if #(.WIDTH(8))  b8 ();
    bit_serial_add_ctrl_if #(.WIDTH(32)) b32 ();

    assign b1.start_i  = start_v && (sel == 1);
    assign b1.op_a_i   = a_v[0:0];
    assign b1.op_b_i   = b_v[0:0];
    assign b1.cin_i    = cin_v;
    assign b1.sub_i    = sub_v;
    assign b8.start_i  = start_v && (sel == 8);
    assign b8.op_a_i   = a_v[7:0];
    assign b8.op_b_i   = b_v[7:0];
    assign b8.cin_i    = cin_v;
    assign b8.sub_i    = sub_v;
    assign b32.start_i = start_v && (sel == 32);
    assign b32.op_a_i  = a_v;
    assign b32.op_b_i  = b_v;
    assign b32.cin_i   = cin_v;
    assign b32.sub_i   = sub_v;

    bit_serial_add_ctrl #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(b1));
    bit_serial_add_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
    bit_serial_add_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));

    logic        done_m, busy_m, cout_m;
    logic [31:0] sum_m;

    always_comb begin
        case (sel)
            1: begin
                done_m = b1.done_o; busy_m = b1.busy_o;
                cout_m = b1.cout_o; sum_m  = {31'b0, b1.sum_o};
            end
            32: begin
                done_m = b32.done_o; busy_m = b32.busy_o;
                cout_m = b32.cout_o; sum_m  = b32.sum_o;
            end
            default: begin
                done_m = b8.done_o; busy_m = b8.busy_o;
                cout_m = b8.cout_o; sum_m  = {24'b0, b8.sum_o};
            end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic c, input logic s);
        a_v = a; b_v = b; cin_v = c; sub_v = s;
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int nbusy);
        cyc = 0;
        nbusy = 0;
        while (!done_m && cyc < 40) begin
            if (busy_m) nbusy++;
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({b8.busy_o, b8.done_o, b8.cout_o, b8.sum_o} !== 11'h000) begin
            n_bad++;
            $display("FAIL reset_w8 busy/done/cout/sum=%b/%b/%b/%h required 0/0/0/00",
                     b8.busy_o, b8.done_o, b8.cout_o, b8.sum_o);
        end
        n_cmp++;
        if ({b1.busy_o, b1.done_o, b1.cout_o, b1.sum_o} !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_w1 outputs nonzero");
        end
        n_cmp++;
        if ({b32.busy_o, b32.done_o, b32.cout_o, b32.sum_o} !== 35'h0) begin
            n_bad++;
            $display("FAIL reset_w32 sum=%h cout=%b required 0", b32.sum_o, b32.cout_o);
        end
        rst = 1'b0;
        tick();
        $display("reset: outputs cleared");
    endtask

    task automatic test_carry_ripple();
        int cyc, nbusy;
        sel = 8;
        start_op(32'hFF, 32'h01, 1'b0, 1'b0);
        wait_done(cyc, nbusy);
        n_cmp++;
        if (!done_m || cyc != 8) begin
            n_bad++;
            $display("FAIL ripple_latency done=%b cycles=%0d required done after 8", done_m, cyc);
        end
        n_cmp++;
        if (nbusy != 8) begin
            n_bad++;
            $display("FAIL ripple_busy busy cycles=%0d required 8", nbusy);
        end
        n_cmp++;
        if (b8.sum_o !== 8'h00 || b8.cout_o !== 1'b1) begin
            n_bad++;
            $display("FAIL ripple_result sum=%h cout=%b required 00 1", b8.sum_o, b8.cout_o);
        end
        $display("op FF+01+0 -> sum=%h cout=%b", b8.sum_o, b8.cout_o);
        tick();
        n_cmp++;
        if (b8.done_o !== 1'b0 || b8.busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL done_pulse done=%b busy=%b required 0 0", b8.done_o, b8.busy_o);
        end
    endtask

    task automatic test_hold_during_run();
        int  cyc;
        bit  held_ok;
        sel = 8;
        start_op(32'h35, 32'h4A, 1'b1, 1'b0);
        cyc = 0;
        held_ok = 1'b1;
        while (!done_m && cyc < 40) begin
            if (b8.sum_o !== 8'h00 || b8.cout_o !== 1'b1) held_ok = 1'b0;
            tick();
            cyc++;
        end
        n_cmp++;
        if (!held_ok) begin
            n_bad++;
            $display("FAIL hold_during_run outputs changed before done, required 00/1 held");
        end
        n_cmp++;
        if (!done_m || b8.sum_o !== 8'h80 || b8.cout_o !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_result done=%b sum=%h cout=%b required 1 80 0",
                     done_m, b8.sum_o, b8.cout_o);
        end
        $display("op 35+4A+1 -> sum=%h cout=%b", b8.sum_o, b8.cout_o);
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc, nbusy;
        sel = 8;
        a_v = 32'h10; b_v = 32'h20; cin_v = 1'b0; sub_v = 1'b0;
        start_v = 1'b1;
        tick();
        a_v = 32'hFF; b_v = 32'hFF; cin_v = 1'b1;
        wait_done(cyc, nbusy);
        n_cmp++;
        if (!done_m || cyc != 8 || b8.sum_o !== 8'h30 || b8.cout_o !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_start done=%b cycles=%0d sum=%h cout=%b required 1 8 30 0",
                     done_m, cyc, b8.sum_o, b8.cout_o);
        end
        $display("op 10+20+0 (start held) -> sum=%h cout=%b", b8.sum_o, b8.cout_o);
        tick();
        start_v = 1'b0;
        n_cmp++;
        if (b8.busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_no_gap busy=%b required 1", b8.busy_o);
        end
        wait_done(cyc, nbusy);
        n_cmp++;
        if (!done_m || cyc != 8 || b8.sum_o !== 8'hFF || b8.cout_o !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_result done=%b cycles=%0d sum=%h cout=%b required 1 8 FF 1",
                     done_m, cyc, b8.sum_o, b8.cout_o);
        end
        $display("op FF+FF+1 (back-to-back) -> sum=%h cout=%b", b8.sum_o, b8.cout_o);
        tick();
    endtask

    task automatic test_reset_mid_run();
        bit saw_done;
        sel = 8;
        start_op(32'h12, 32'h34, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({b8.busy_o, b8.done_o, b8.cout_o, b8.sum_o} !== 11'h000) begin
            n_bad++;
            $display("FAIL abort_reset busy=%b done=%b cout=%b sum=%h required 0 0 0 00",
                     b8.busy_o, b8.done_o, b8.cout_o, b8.sum_o);
        end
        saw_done = 1'b0;
        repeat (12) begin
            if (b8.done_o) saw_done = 1'b1;
            tick();
        end
        n_cmp++;
        if (saw_done) begin
            n_bad++;
            $display("FAIL abort_no_done done pulse seen=1 required 0");
        end
        $display("op 12+34 aborted by reset -> sum=%h cout=%b", b8.sum_o, b8.cout_o);
    endtask

    task automatic test_subtract();
        int         cyc, nbusy;
        logic [7:0] exp_s1, exp_s2;
        logic       exp_c1, exp_c2;
`ifdef BSA_SUB_EN
        exp_s1 = 8'hFE; exp_c1 = 1'b0;
        exp_s2 = 8'h02; exp_c2 = 1'b1;
`else
        exp_s1 = 8'h0C; exp_c1 = 1'b0;
        exp_s2 = 8'h0C; exp_c2 = 1'b0;
`endif
        sel = 8;
        start_op(32'h05, 32'h07, 1'b0, 1'b1);
        wait_done(cyc, nbusy);
        n_cmp++;
        if (!done_m || b8.sum_o !== exp_s1 || b8.cout_o !== exp_c1) begin
            n_bad++;
            $display("FAIL sub_05_07 sum=%h cout=%b required %h %b",
                     b8.sum_o, b8.cout_o, exp_s1, exp_c1);
        end
        $display("op 05 sub 07 -> sum=%h cout=%b", b8.sum_o, b8.cout_o);
        tick();
        start_op(32'h07, 32'h05, 1'b0, 1'b1);
        wait_done(cyc, nbusy);
        n_cmp++;
        if (!done_m || b8.sum_o !== exp_s2 || b8.cout_o !== exp_c2) begin
            n_bad++;
            $display("FAIL sub_07_05 sum=%h cout=%b required %h %b",
                     b8.sum_o, b8.cout_o, exp_s2, exp_c2);
        end
        $display("op 07 sub 05 -> sum=%h cout=%b", b8.sum_o, b8.cout_o);
        tick();
    endtask

    task automatic test_random(input int w, input int n);
        int          cyc, nbusy;
        logic [32:0] mask, full;
        logic [31:0] a, b, exp_sum;
        logic        c, exp_cout;
        sel = w;
        mask = (33'd1 << w) - 33'd1;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            b = $urandom;
            c = 1'($urandom_range(0, 1));
            full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {32'b0, c};
            exp_sum  = full[31:0] & mask[31:0];
            exp_cout = full[w];
            start_op(a, b, c, 1'b0);
            wait_done(cyc, nbusy);
            n_cmp++;
            if (!done_m || cyc != w) begin
                n_bad++;
                $display("FAIL rand_w%0d_latency done=%b cycles=%0d required %0d", w, done_m, cyc, w);
            end
            n_cmp++;
            if (sum_m !== exp_sum) begin
                n_bad++;
                $display("FAIL rand_w%0d_sum sum=%h required %h", w, sum_m, exp_sum);
            end
            n_cmp++;
            if (cout_m !== exp_cout) begin
                n_bad++;
                $display("FAIL rand_w%0d_cout cout=%b required %b", w, cout_m, exp_cout);
            end
            $display("rand w=%0d a=%h b=%h cin=%b -> sum=%h cout=%b",
                     w, a & mask[31:0], b & mask[31:0], c, sum_m, cout_m);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_hold_during_run();
        test_back_to_back();
        test_reset_mid_run();
        test_subtract();
        test_random(1, 200);
        test_random(8, 200);
        test_random(32, 200);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
